wb_select_pipe: RTL and testbench
=================================

# wb_select_pipe

Parametrised, registered writeback-select stage for the RISC-V core. It selects one of NSRC result sources for the register file. It performs load-data extraction on the memory source: byte/halfword/word alignment with sign or zero extension. It buffers one result through a valid/ready skid register so the writeback path can stall without dropping data. It sits between the memory-access stage and the register file and replaces the fixed 2:1 ALU/memory select.

## Interface
Parameters:
- NSRC, 4, number of 32-bit sources. Index 0 is the ALU result, 1 is memory read data, 2 is PC+4, 3 is the immediate.
- MEM_SRC, 1, source index that receives load extraction.
- SELW, $clog2(NSRC) (localparam), width of the select.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept. Equals !skid_valid and is forced 0 while rst=1.
- in_src  in  NSRC*32  packed sources; source k is bits [32k+31:32k].
- in_sel  in  SELW  source select (MemtoReg generalised).
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_addr_lo  in  2  byte offset of the load address.
- in_rd  in  5  destination register.
- in_regwrite  in  1  write enable from the control unit.
- out_valid  out  1  result valid.
- out_ready  in  1  register file / hazard logic accepts.
- out_data  out  32  selected, extracted result.
- out_rd  out  5  destination register.
- out_we  out  1  write enable. Equals in_regwrite & !err & (rd!=0).
- out_err  out  1  illegal select, illegal funct3 or misaligned load.

## Operation
- The handshake transfers on in_valid&in_ready (input) and on out_valid&out_ready (output).
- Select and extraction are combinational on the input side. The result is captured into the main register (out_*) or the skid register.
- For in_sel != MEM_SRC, the data is the selected source unchanged.
- For in_sel == MEM_SRC, the word W = in_src[MEM_SRC] is processed as follows:
  - LB/LBU: byte W[8*addr_lo+:8], sign- or zero-extended.
  - LH/LHU: half W[16*addr_lo[1]+:16], sign- or zero-extended. addr_lo[0]=1 is misaligned.
  - LW: W. addr_lo!=0 is misaligned.
- Error cases: in_sel >= NSRC, funct3 not in the supported set (memory source only), or misaligned. Any of these gives data=0, err=1, we=0.
- Writes to x0 are forced to we=0. The data still passes through and err is unaffected.
- Skid states:
  - EMPTY (out_valid=0, skid_valid=0).
  - ONE (out_valid=1, skid_valid=0).
  - TWO (out_valid=1, skid_valid=1).
- State transitions:
  - EMPTY: accepting goes to ONE.
  - ONE:
    - Accept with no drain goes to TWO; the input goes to skid.
    - Accept with drain stays in ONE; the input goes to main.
    - Drain only goes to EMPTY.
  - TWO: in_ready=0. Drain moves skid into main and goes to ONE.
- Ordering is strictly FIFO. Nothing is dropped or duplicated.

## Timing
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 result per cycle while out_ready=1.
- in_ready is a registered function of state, with no combinational path from out_ready. This breaks the stall timing path.
- Reset values: out_valid=0, out_data=0, out_rd=0, out_we=0, out_err=0, skid_valid=0, in_ready=0 during rst and 1 on the first cycle after.
- Reset mid-operation: both entries are discarded in the same cycle. Input presented while rst=1 is ignored.
- out_* stays stable while out_valid&!out_ready, following the standard valid/ready rule.
- Simultaneous accept and drain in ONE: the old main leaves and the new input enters main in the same edge, with no bubble.

## Structure
- A shared package `wb_pkg` holds:
  - source index constants SRC_ALU=0, SRC_MEM=1, SRC_PC4=2, SRC_IMM=3;
  - funct3 load constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - a packed struct wb_entry_t {data[31:0], rd[4:0], we, err}.
- One sub-module, `load_extract`: combinational; inputs are word, funct3 and addr_lo; outputs are data and err. It is instantiated once in the top.
- The skid logic stays in the top module as two wb_entry_t registers plus two valid bits.

## Test plan
- ALU path: sel=0, src0=0x1234_5678, rd=5, regwrite=1, out_ready=1. Next cycle: out_valid=1, data=0x1234_5678, we=1, err=0.
- Loads: memory word 0x80FF_7F01.
  - LB at offset 1 gives 0x0000_007F.
  - LB at offset 3 gives 0xFFFF_FF80.
  - LHU at offset 2 gives 0x0000_80FF.
  - LH at offset 2 gives 0xFFFF_80FF.
- Errors:
  - LW at addr_lo=2 gives data=0, err=1, we=0.
  - sel=NSRC (with an NSRC=3 build) gives err=1.
  - rd=0 with regwrite=1 gives we=0, err=0.
- Backpressure: stream 0x1, 0x2, 0x3 with out_ready=0 for 3 cycles.
  - in_ready drops after the second accept (TWO).
  - On release, outputs are 0x1, 0x2, 0x3 in order, with no loss.
  - Full-rate streaming with out_ready=1 has no bubbles.
- Reset mid-operation: assert rst while in TWO. The next cycle has out_valid=0, then in_ready=1. The first post-reset input emerges alone.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback-select stage.
// Source indices, load funct3 encodings and the buffered result entry.
package wb_pkg;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_IMM = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        err;
  } wb_entry_t;

endpackage

// File: rtl/load_extract.sv
// Load-data extraction: byte/half/word alignment with sign or zero extension.
// Unsupported funct3 or a misaligned offset flags err and returns zero data.
module load_extract
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign byte_w = word[{addr_lo, 3'b000} +: 8];
  assign half_w = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_w[7]}}, byte_w};
      F3_LBU: data = {24'b0, byte_w};
      F3_LH:  begin data = {{16{half_w[15]}}, half_w}; err = addr_lo[0]; end
      F3_LHU: begin data = {16'b0, half_w};            err = addr_lo[0]; end
      F3_LW:  begin data = word;                       err = |addr_lo;   end
      default: err = 1'b1;
    endcase
    if (err) data = '0;
  end

endmodule

// File: rtl/wb_select_pipe.sv
// Registered writeback-select stage: NSRC-way select, load extraction on the
// memory source, and a two-entry valid/ready skid buffer toward the regfile.
module wb_select_pipe
  import wb_pkg::*;
#(
  parameter  int NSRC    = 4,
  parameter  int MEM_SRC = SRC_MEM,
  localparam int SELW    = $clog2(NSRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NSRC*32-1:0]   in_src,
  input  logic [SELW-1:0]      in_sel,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_addr_lo,
  input  logic [4:0]           in_rd,
  input  logic                 in_regwrite,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [4:0]           out_rd,
  output logic                 out_we,
  output logic                 out_err
);

  logic [NSRC-1:0][31:0] src;
  logic [31:0] sel_word, ld_data;
  logic        sel_ok, is_mem, ld_err, err;
  wb_entry_t   nxt, main_q, skid_q;
  logic        main_vld, skid_vld;
  logic        acc, drn;

  assign src = in_src;

  // Explicit compare loop keeps out-of-range selects (non power-of-two NSRC) well defined.
  always_comb begin
    sel_word = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SELW'(k)) begin
        sel_word = src[k];
        sel_ok   = 1'b1;
      end
    end
  end

  load_extract u_ext (
    .word    (src[MEM_SRC]),
    .funct3  (in_funct3),
    .addr_lo (in_addr_lo),
    .data    (ld_data),
    .err     (ld_err)
  );

  assign is_mem = (in_sel == SELW'(MEM_SRC));
  assign err    = !sel_ok || (is_mem && ld_err);

  always_comb begin
    nxt      = '0;
    nxt.err  = err;
    nxt.data = err ? 32'h0 : (is_mem ? ld_data : sel_word);
    nxt.rd   = in_rd;
    nxt.we   = in_regwrite && !err && (in_rd != 5'd0);
  end

  // in_ready depends only on registered state (and reset), never on out_ready.
  assign in_ready = !skid_vld && !rst;
  assign acc      = in_valid && in_ready;
  assign drn      = main_vld && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || drn) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= acc;
        if (acc) main_q <= nxt;
      end
    end else if (acc) begin
      skid_q   <= nxt;
      skid_vld <= 1'b1;
    end
  end

  assign out_valid = main_vld;
  assign out_data  = main_q.data;
  assign out_rd    = main_q.rd;
  assign out_we    = main_q.we;
  assign out_err   = main_q.err;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe: scoreboard of expected entries, checked
// when each result leaves the stage; plus an NSRC=3 build for the select error.
module tb_wb_select_pipe;
  import wb_pkg::*;

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [127:0] in_src = '0;
  logic [1:0]   in_sel = '0;
  logic [2:0]   in_funct3 = F3_LW;
  logic [1:0]   in_addr_lo = '0;
  logic [4:0]   in_rd = '0;
  logic         in_regwrite = 1'b0;
  logic         out_valid, out_ready = 1'b0;
  logic [31:0]  out_data;
  logic [4:0]   out_rd;
  logic         out_we, out_err;

  logic         in_ready3, out_valid3;
  logic [31:0]  out_data3;
  logic [4:0]   out_rd3;
  logic         out_we3, out_err3;

  int checks = 0, errors = 0, xfers = 0;
  wb_entry_t q[$];

  always #5 clk = ~clk;

  wb_select_pipe #(.NSRC(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_sel(in_sel), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_we(out_we), .out_err(out_err)
  );

  wb_select_pipe #(.NSRC(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_src(in_src[95:0]), .in_sel(in_sel), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid3), .out_ready(1'b1), .out_data(out_data3),
    .out_rd(out_rd3), .out_we(out_we3), .out_err(out_err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare at the negedge preceding each output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        wb_entry_t e;
        e = q.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_rd",   32'(out_rd), 32'(e.rd));
        chk("sb_we",   32'(out_we), 32'(e.we));
        chk("sb_err",  32'(out_err), 32'(e.err));
      end
      xfers++;
    end
  end

  function automatic logic [127:0] srcs(input logic [31:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  // Drive one input, push its expected result, hold until accepted; returns #1 after the edge.
  task automatic send(input logic [127:0] s, input logic [1:0] sel, input logic [2:0] f3,
                      input logic [1:0] a, input logic [4:0] rd, input logic rw,
                      input logic [31:0] ed, input logic ewe, input logic eerr,
                      output int waited);
    wb_entry_t e;
    @(negedge clk);
    in_src = s; in_sel = sel; in_funct3 = f3; in_addr_lo = a;
    in_rd = rd; in_regwrite = rw; in_valid = 1'b1;
    e.data = ed; e.rd = rd; e.we = ewe; e.err = eerr;
    q.push_back(e);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_wait();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    logic [31:0] mw;
    mw = 32'h80FF_7F01;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_rd",    32'(out_rd), 32'd0);
    chk("rst_out_we",    32'(out_we), 32'd0);
    chk("rst_out_err",   32'(out_err), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    send(srcs(32'h1234_5678, 0, 0, 0), 2'd0, F3_LW, 2'd0, 5'd5, 1'b1, 32'h1234_5678, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("alu_latency_valid", 32'(out_valid), 32'd1);
    chk("alu_latency_data",  out_data, 32'h1234_5678);

    // Load extraction on the memory source.
    send(srcs(0, mw, 0, 0), 2'd1, F3_LB,  2'd1, 5'd6, 1'b1, 32'h0000_007F, 1'b1, 1'b0, w);
    send(srcs(0, mw, 0, 0), 2'd1, F3_LB,  2'd3, 5'd6, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, w);
    send(srcs(0, mw, 0, 0), 2'd1, F3_LHU, 2'd2, 5'd7, 1'b1, 32'h0000_80FF, 1'b1, 1'b0, w);
    send(srcs(0, mw, 0, 0), 2'd1, F3_LH,  2'd2, 5'd7, 1'b1, 32'hFFFF_80FF, 1'b1, 1'b0, w);
    send(srcs(0, mw, 0, 0), 2'd1, F3_LBU, 2'd3, 5'd8, 1'b1, 32'h0000_0080, 1'b1, 1'b0, w);
    send(srcs(0, mw, 0, 0), 2'd1, F3_LH,  2'd0, 5'd8, 1'b1, 32'h0000_7F01, 1'b1, 1'b0, w);
    send(srcs(0, mw, 0, 0), 2'd1, F3_LW,  2'd0, 5'd9, 1'b1, 32'h80FF_7F01, 1'b1, 1'b0, w);

    // Error cases and x0 suppression.
    send(srcs(0, mw, 0, 0), 2'd1, F3_LW,  2'd2, 5'd9, 1'b1, 32'h0, 1'b0, 1'b1, w);
    send(srcs(0, mw, 0, 0), 2'd1, F3_LHU, 2'd1, 5'd9, 1'b1, 32'h0, 1'b0, 1'b1, w);
    send(srcs(0, mw, 0, 0), 2'd1, 3'b011, 2'd0, 5'd9, 1'b1, 32'h0, 1'b0, 1'b1, w);
    send(srcs(32'hAAAA_5555, mw, 0, 0), 2'd0, 3'b111, 2'd3, 5'd10, 1'b1, 32'hAAAA_5555, 1'b1, 1'b0, w);
    send(srcs(32'hDEAD_BEEF, 0, 0, 0), 2'd0, F3_LW, 2'd0, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, w);
    send(srcs(0, 0, 32'h0000_1004, 0), 2'd2, F3_LW, 2'd0, 5'd1, 1'b0, 32'h0000_1004, 1'b0, 1'b0, w);
    send(srcs(0, 0, 0, 32'hFFFF_F800), 2'd3, F3_LW, 2'd0, 5'd11, 1'b1, 32'hFFFF_F800, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("nsrc3_sel_err",  32'(out_err3), 32'd1);
    chk("nsrc3_sel_data", out_data3, 32'd0);
    chk("nsrc3_sel_we",   32'(out_we3), 32'd0);
    drain_wait();

    // Full-rate streaming: no waits on input, output valid every cycle.
    send(srcs(32'h10, 0, 0, 0), 2'd0, F3_LW, 2'd0, 5'd12, 1'b1, 32'h10, 1'b1, 1'b0, w);
    for (int i = 1; i < 4; i++) begin
      send(srcs(32'h10 + 32'(i), 0, 0, 0), 2'd0, F3_LW, 2'd0, 5'd12, 1'b1,
           32'h10 + 32'(i), 1'b1, 1'b0, w);
      chk("stream_no_wait", 32'(w), 32'd0);
      chk("stream_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    drain_wait();

    // Backpressure: fill both entries, hold, then release.
    base = xfers;
    out_ready = 1'b0;
    send(srcs(32'h1, 0, 0, 0), 2'd0, F3_LW, 2'd0, 5'd13, 1'b1, 32'h1, 1'b1, 1'b0, w);
    send(srcs(32'h2, 0, 0, 0), 2'd0, F3_LW, 2'd0, 5'd13, 1'b1, 32'h2, 1'b1, 1'b0, w);
    chk("bp_in_ready_two", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_data",  out_data, 32'h1);
    fork
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join_none
    send(srcs(32'h3, 0, 0, 0), 2'd0, F3_LW, 2'd0, 5'd13, 1'b1, 32'h3, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    drain_wait();
    repeat (2) @(negedge clk);
    chk("bp_xfer_count", 32'(xfers - base), 32'd3);

    // Reset while holding two entries.
    out_ready = 1'b0;
    send(srcs(32'hA, 0, 0, 0), 2'd0, F3_LW, 2'd0, 5'd14, 1'b1, 32'hA, 1'b1, 1'b0, w);
    send(srcs(32'hB, 0, 0, 0), 2'd0, F3_LW, 2'd0, 5'd14, 1'b1, 32'hB, 1'b1, 1'b0, w);
    @(negedge clk);
    rst = 1'b1;
    in_src = srcs(32'hBAD, 0, 0, 0);
    in_valid = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
    base = xfers;
    out_ready = 1'b1;
    send(srcs(32'hC, 0, 0, 0), 2'd0, F3_LW, 2'd0, 5'd15, 1'b1, 32'hC, 1'b1, 1'b0, w);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_single_out", 32'(xfers - base), 32'd1);
    chk("midrst_sb_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
